// File: rtl/axi_ic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_ic_pkg
// Description : Shared types and constants for the AXI interconnect B-channel.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_ic_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } b_state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam int NUM_SLAVES  = 4;
    localparam int NUM_MASTERS = 2;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter; priority starts after the last grant.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     i_req,
    input  logic             i_advance,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_grant_idx
);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    // Scan from r_ptr upward with wrap; the first requester wins.
    always_comb begin : p_grant
        int               j;
        logic [IDX_W-1:0] j_idx;
        j       = 0;
        j_idx   = '0;
        o_grant = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = int'(r_ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            j_idx = IDX_W'(j);
            if (!w_found && i_req[j_idx]) begin
                w_found = 1'b1;
                w_idx   = j_idx;
            end
        end
        if (w_found) begin
            o_grant[w_idx] = 1'b1;
        end
    end

    assign o_grant_idx = w_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_advance && w_found) begin
            r_ptr <= (int'(w_idx) == N - 1) ? '0 : w_idx + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/write_resp_channel_mux.sv
`default_nettype none
// ============================================================================
// Module      : write_resp_channel_mux
// Description : Routes slave write responses to masters by bid, tracking
//               per-slave outstanding writes.
// Revision    : 1.0 - initial release
// ============================================================================
module write_resp_channel_mux
    import axi_ic_pkg::*;
#(
    parameter int Num_OF_Masters  = NUM_MASTERS,
    parameter int Masters_ID_Size = $clog2(Num_OF_Masters),
    parameter int Num_Of_Slaves   = NUM_SLAVES,
    parameter int Max_Outstanding = 4
) (
    input  logic                                          ACLK,
    input  logic                                          ARESET,
    input  logic [Num_Of_Slaves-1:0][Masters_ID_Size-1:0] Slv_bid,
    input  logic [Num_Of_Slaves-1:0][1:0]                 Slv_bresp,
    input  logic [Num_Of_Slaves-1:0]                      Slv_bvalid,
    output logic [Num_Of_Slaves-1:0]                      Slv_bready,
    output logic [Num_OF_Masters-1:0][1:0]                Mst_bresp,
    output logic [Num_OF_Masters-1:0]                     Mst_bvalid,
    input  logic [Num_OF_Masters-1:0]                     Mst_bready,
    input  logic [Num_Of_Slaves-1:0]                      AW_Q_Enables,
    input  logic                                          AW_handshake,
    output logic [Num_Of_Slaves-1:0]                      Outstanding_Full,
    output logic                                          Unexpected_Resp
);

    localparam int c_CNT_W = $clog2(Max_Outstanding + 1);
    localparam int c_IDX_W = (Num_Of_Slaves > 1) ? $clog2(Num_Of_Slaves) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(Max_Outstanding);

    b_state_t                   r_state;
    b_state_t                   w_state_nxt;
    logic [Masters_ID_Size-1:0] r_bid;
    logic [1:0]                 r_bresp;
    logic                       r_unexp;
    logic [Num_Of_Slaves-1:0]   w_grant;
    logic [Num_Of_Slaves-1:0]   w_cnt_err;
    logic [c_IDX_W-1:0]         w_grant_idx;
    logic                       w_accept;
    logic                       w_bid_bad;
    logic                       w_mst_done;

    rr_arbiter #(
        .N     (Num_Of_Slaves),
        .IDX_W (c_IDX_W)
    ) u_arb (
        .clk         (ACLK),
        .rst         (ARESET),
        .i_req       (Slv_bvalid),
        .i_advance   (w_accept),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    assign Slv_bready = (r_state == IDLE && !ARESET) ? w_grant : '0;
    assign w_accept   = |Slv_bready;

    // Only reachable when Num_OF_Masters is not a power of two.
    assign w_bid_bad = (int'(r_bid) >= Num_OF_Masters);

    for (genvar m = 0; m < Num_OF_Masters; m++) begin : g_mst
        assign Mst_bvalid[m] = (r_state == RESP) && !w_bid_bad && (int'(r_bid) == m);
        assign Mst_bresp[m]  = Mst_bvalid[m] ? r_bresp : 2'b00;
    end

    assign w_mst_done = |(Mst_bvalid & Mst_bready);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = RESP;
            RESP:    if (w_bid_bad || w_mst_done) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_bid   <= '0;
            r_bresp <= '0;
        end else if (w_accept) begin
            r_bid   <= Slv_bid[w_grant_idx];
            r_bresp <= Slv_bresp[w_grant_idx];
        end
    end

    // A same-cycle AW and B on one slave cancel out and never flag an error.
    for (genvar s = 0; s < Num_Of_Slaves; s++) begin : g_cnt
        logic [c_CNT_W-1:0] r_count;
        logic               w_inc;
        logic               w_dec;

        assign w_inc = AW_handshake && AW_Q_Enables[s];
        assign w_dec = Slv_bready[s];
        assign w_cnt_err[s] = (w_inc && !w_dec && (r_count == c_CNT_MAX)) ||
                              (w_dec && !w_inc && (r_count == '0));

        always_ff @(posedge ACLK) begin
            if (ARESET) begin
                r_count <= '0;
            end else if (w_inc && !w_dec && (r_count != c_CNT_MAX)) begin
                r_count <= r_count + 1'b1;
            end else if (w_dec && !w_inc && (r_count != '0)) begin
                r_count <= r_count - 1'b1;
            end
        end

        assign Outstanding_Full[s] = (r_count == c_CNT_MAX);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_unexp <= 1'b0;
        end else begin
            r_unexp <= (|w_cnt_err) || ((r_state == RESP) && w_bid_bad);
        end
    end

    assign Unexpected_Resp = r_unexp;

endmodule
`default_nettype wire

// File: tb/tb_write_resp_channel_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_write_resp_channel_mux
// Description : Directed scoreboard bench for the B-channel response mux.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_write_resp_channel_mux;
    import axi_ic_pkg::*;

    localparam int NM = 2;
    localparam int NS = 4;

    logic                ACLK;
    logic                ARESET;
    logic [NS-1:0][0:0]  Slv_bid;
    logic [NS-1:0][1:0]  Slv_bresp;
    logic [NS-1:0]       Slv_bvalid;
    logic [NS-1:0]       Slv_bready;
    logic [NM-1:0][1:0]  Mst_bresp;
    logic [NM-1:0]       Mst_bvalid;
    logic [NM-1:0]       Mst_bready;
    logic [NS-1:0]       AW_Q_Enables;
    logic                AW_handshake;
    logic [NS-1:0]       Outstanding_Full;
    logic                Unexpected_Resp;

    write_resp_channel_mux dut (
        .ACLK             (ACLK),
        .ARESET           (ARESET),
        .Slv_bid          (Slv_bid),
        .Slv_bresp        (Slv_bresp),
        .Slv_bvalid       (Slv_bvalid),
        .Slv_bready       (Slv_bready),
        .Mst_bresp        (Mst_bresp),
        .Mst_bvalid       (Mst_bvalid),
        .Mst_bready       (Mst_bready),
        .AW_Q_Enables     (AW_Q_Enables),
        .AW_handshake     (AW_handshake),
        .Outstanding_Full (Outstanding_Full),
        .Unexpected_Resp  (Unexpected_Resp)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        int         mst;
        logic [1:0] resp;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    logic [3:0] rr_exp [8];

    task automatic push_exp(input int m, input logic [1:0] r);
        exp_t e;
        e.mst  = m;
        e.resp = r;
        sb.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic at_neg();
        @(negedge ACLK);
    endtask

    task automatic do_reset();
        ARESET       = 1'b1;
        Slv_bvalid   = '0;
        AW_handshake = 1'b0;
        step();
        ARESET       = 1'b0;
    endtask

    // Every completed master handshake must match the oldest expected response.
    always @(negedge ACLK) begin
        for (int m = 0; m < NM; m++) begin
            if (Mst_bvalid[m] && Mst_bready[m]) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_extra: master %0d got bresp %b with nothing expected", m, Mst_bresp[m]);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.mst != m || mon_e.resp !== Mst_bresp[m]) begin
                        n_err++;
                        $display("FAIL sb_resp: got master %0d bresp %b, expected master %0d bresp %b",
                                 m, Mst_bresp[m], mon_e.mst, mon_e.resp);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rr_exp = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
        ARESET       = 1'b1;
        Slv_bid      = '0;
        Slv_bresp    = '0;
        Slv_bvalid   = '1;
        Mst_bready   = '0;
        AW_Q_Enables = '0;
        AW_handshake = 1'b0;

        // Reset values, with every slave requesting during reset
        repeat (2) step();
        at_neg();
        check("rst_slv_bready", 32'(Slv_bready), 32'h0);
        check("rst_mst_bvalid", 32'(Mst_bvalid), 32'h0);
        check("rst_mst_bresp", 32'(Mst_bresp), 32'h0);
        check("rst_full", 32'(Outstanding_Full), 32'h0);
        check("rst_unexp", 32'(Unexpected_Resp), 32'h0);
        Slv_bvalid = '0;
        ARESET     = 1'b0;
        step();

        // Single response: slave 2 -> master 1, one-cycle latency
        Slv_bid[2]   = 1'b1;
        Slv_bresp[2] = OKAY;
        Slv_bvalid   = 4'b0100;
        Mst_bready   = 2'b10;
        push_exp(1, OKAY);
        at_neg();
        check("single_bready_N", 32'(Slv_bready), 32'h4);
        check("single_bvalid_N", 32'(Mst_bvalid), 32'h0);
        step();
        Slv_bvalid = '0;
        at_neg();
        check("single_bvalid_N1", 32'(Mst_bvalid), 32'h2);
        check("single_bresp_N1", 32'(Mst_bresp), 32'h0);
        check("single_unexp_cnt0", 32'(Unexpected_Resp), 32'h1);
        step();
        at_neg();
        check("single_idle_N2", 32'(Mst_bvalid), 32'h0);
        check("single_unexp_clr", 32'(Unexpected_Resp), 32'h0);
        step();

        // Round robin among slaves 0,1,3
        do_reset();
        Slv_bid[0] = 1'b0; Slv_bresp[0] = OKAY;
        Slv_bid[1] = 1'b1; Slv_bresp[1] = EXOKAY;
        Slv_bid[3] = 1'b0; Slv_bresp[3] = DECERR;
        Mst_bready = 2'b11;
        Slv_bvalid = 4'b1011;
        push_exp(0, OKAY);
        push_exp(1, EXOKAY);
        push_exp(0, DECERR);
        push_exp(0, OKAY);
        for (int c = 0; c < 8; c++) begin
            at_neg();
            check($sformatf("rr_cycle%0d", c), 32'(Slv_bready), 32'(rr_exp[c]));
            step();
        end
        Slv_bvalid = '0;

        // Backpressure: master 0 holds off for 5 cycles, slave 2 keeps requesting
        Slv_bid[1] = 1'b0; Slv_bresp[1] = SLVERR;
        Slv_bid[2] = 1'b1; Slv_bresp[2] = OKAY;
        Mst_bready = 2'b00;
        Slv_bvalid = 4'b0110;
        push_exp(0, SLVERR);
        at_neg();
        check("hold_grant", 32'(Slv_bready), 32'h2);
        step();
        Slv_bvalid = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            at_neg();
            check($sformatf("hold_bvalid%0d", k), 32'(Mst_bvalid), 32'h1);
            check($sformatf("hold_bresp%0d", k), 32'(Mst_bresp), 32'h2);
            check($sformatf("hold_bready%0d", k), 32'(Slv_bready), 32'h0);
            step();
        end
        Mst_bready = 2'b11;
        push_exp(1, OKAY);
        step();
        at_neg();
        check("hold_next_grant", 32'(Slv_bready), 32'h4);
        step();
        Slv_bvalid = '0;
        step();

        // Outstanding counter: fill, saturate, simultaneous inc/dec, drain
        do_reset();
        AW_Q_Enables = 4'b0010;
        AW_handshake = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            at_neg();
            check($sformatf("full_aw%0d", k + 1), 32'(Outstanding_Full), (k == 3) ? 32'h2 : 32'h0);
        end
        check("full_no_unexp", 32'(Unexpected_Resp), 32'h0);
        step();
        at_neg();
        check("sat_unexp", 32'(Unexpected_Resp), 32'h1);
        check("sat_full", 32'(Outstanding_Full), 32'h2);
        Slv_bid[1]   = 1'b0;
        Slv_bresp[1] = OKAY;
        Slv_bvalid   = 4'b0010;
        push_exp(0, OKAY);
        step();
        AW_handshake = 1'b0;
        Slv_bvalid   = '0;
        at_neg();
        check("same_cycle_full", 32'(Outstanding_Full), 32'h2);
        check("same_cycle_unexp", 32'(Unexpected_Resp), 32'h0);
        step();
        Slv_bvalid = 4'b0010;
        push_exp(0, OKAY);
        step();
        Slv_bvalid = '0;
        at_neg();
        check("dec_full", 32'(Outstanding_Full), 32'h0);
        step();

        // Response from slave 3 with nothing outstanding
        Slv_bid[3]   = 1'b1;
        Slv_bresp[3] = EXOKAY;
        Slv_bvalid   = 4'b1000;
        push_exp(1, EXOKAY);
        step();
        Slv_bvalid = '0;
        at_neg();
        check("unexp_pulse", 32'(Unexpected_Resp), 32'h1);
        check("unexp_forwarded", 32'(Mst_bvalid), 32'h2);
        step();
        at_neg();
        check("unexp_one_cycle", 32'(Unexpected_Resp), 32'h0);
        step();

        // Reset while a response is held
        Slv_bid[0]   = 1'b0;
        Slv_bresp[0] = SLVERR;
        Slv_bvalid   = 4'b0001;
        Mst_bready   = 2'b00;
        AW_Q_Enables = 4'b0100;
        AW_handshake = 1'b1;
        step();
        Slv_bvalid   = '0;
        AW_handshake = 1'b0;
        at_neg();
        check("mid_rst_pre_bvalid", 32'(Mst_bvalid), 32'h1);
        ARESET     = 1'b1;
        Slv_bvalid = '1;
        step();
        at_neg();
        check("mid_rst_bvalid", 32'(Mst_bvalid), 32'h0);
        check("mid_rst_bready", 32'(Slv_bready), 32'h0);
        ARESET       = 1'b0;
        Slv_bvalid   = '0;
        AW_Q_Enables = 4'b0100;
        AW_handshake = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            at_neg();
            check($sformatf("mid_rst_cnt%0d", k + 1), 32'(Outstanding_Full), (k == 3) ? 32'h4 : 32'h0);
        end
        AW_handshake = 1'b0;
        Slv_bid      = '0;
        Slv_bresp    = '0;
        Mst_bready   = 2'b11;
        Slv_bvalid   = 4'b1111;
        #1;
        check("mid_rst_next_grant", 32'(Slv_bready), 32'h1);
        push_exp(0, OKAY);
        step();
        Slv_bvalid = '0;
        repeat (3) step();

        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
